// File: rtl/pfb_multichannel_decimator_hls_deadlock_reporter.sv
// Debounces the HLS dataflow deadlock flag and emits one snapshot record per
// confirmed deadlock over a valid/ready port, with a saturating event count.
module pfb_multichannel_decimator_hls_deadlock_reporter #(
  parameter int AXIS_W         = 12,
  parameter int IDLE_W         = 6,
  parameter int IBLK_W         = 3,
  parameter int CONFIRM_CYCLES = 16,
  parameter int TS_W           = 32,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0] inst_idle_sigs,
  input  logic [IBLK_W-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [TS_W-1:0]   rpt_timestamp,
  output logic [AXIS_W-1:0] rpt_axis,
  output logic [IDLE_W-1:0] rpt_idle,
  output logic [IBLK_W-1:0] rpt_inst_block,
  output logic              deadlock_active,
  output logic [CNT_W-1:0]  event_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_REPORT  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [15:0]      RC_LAST = 16'(CONFIRM_CYCLES - 1);
  localparam logic [15:0]      RC_ONE  = 16'd1;
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] rc;
  logic [15:0] rc_nxt;
  logic [TS_W-1:0] ts;
  logic        capture;
  logic        handshake;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
    end
  end

  // Next-state logic; clear overrides every transition, including capture
  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE: begin
        if (!block) begin
          rc_nxt = '0;
        end else if (CONFIRM_CYCLES == 1) begin
          capture   = 1'b1;
          state_nxt = S_REPORT;
          rc_nxt    = '0;
        end else begin
          rc_nxt    = RC_ONE;
          state_nxt = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (!block) begin
          state_nxt = S_IDLE;
          rc_nxt    = '0;
        end else if (rc == RC_LAST) begin
          capture   = 1'b1;
          state_nxt = S_REPORT;
          rc_nxt    = '0;
        end else begin
          rc_nxt = rc + RC_ONE;
        end
      end
      S_REPORT: begin
        if (rpt_valid && rpt_ready) begin
          handshake = 1'b1;
          state_nxt = S_RELEASE;
          rc_nxt    = '0;
        end
      end
      S_RELEASE: begin
        if (block) begin
          rc_nxt = '0;
        end else if (rc == RC_LAST) begin
          state_nxt = S_IDLE;
          rc_nxt    = '0;
        end else begin
          rc_nxt = rc + RC_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        rc_nxt    = '0;
      end
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
      rc_nxt    = '0;
      capture   = 1'b0;
      handshake = 1'b0;
    end
  end

  // Output decode of the registered state
  always_comb begin
    deadlock_active = (state == S_REPORT) || (state == S_RELEASE);
  end

  // Snapshot, valid flag, timestamp and event counter
  always_ff @(posedge clock) begin
    if (reset) begin
      ts             <= '0;
      rpt_valid      <= 1'b0;
      rpt_timestamp  <= '0;
      rpt_axis       <= '0;
      rpt_idle       <= '0;
      rpt_inst_block <= '0;
      event_count    <= '0;
    end else begin
      ts <= ts + TS_ONE;
      if (clear) begin
        rpt_valid   <= 1'b0;
        event_count <= '0;
      end else if (capture) begin
        rpt_valid      <= 1'b1;
        rpt_timestamp  <= ts;
        rpt_axis       <= axis_block_sigs;
        rpt_idle       <= inst_idle_sigs;
        rpt_inst_block <= inst_block_sigs;
        event_count    <= sat_inc(event_count);
      end else if (handshake) begin
        rpt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfb_multichannel_decimator_hls_deadlock_reporter.sv
// Scoreboard bench for the deadlock reporter: expected records are queued when
// a deadlock is driven and compared when the report handshake is observed.
module tb_pfb_multichannel_decimator_hls_deadlock_reporter;

  localparam int AXIS_W = 12;
  localparam int IDLE_W = 6;
  localparam int IBLK_W = 3;
  localparam int CONF   = 16;

  typedef struct packed {
    logic [31:0]       ts;
    logic [AXIS_W-1:0] axis;
    logic [IDLE_W-1:0] idle;
    logic [IBLK_W-1:0] iblk;
  } rec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, block, clear, rpt_ready;
  logic [AXIS_W-1:0] axis_block_sigs;
  logic [IDLE_W-1:0] inst_idle_sigs;
  logic [IBLK_W-1:0] inst_block_sigs;
  logic              rpt_valid, deadlock_active;
  logic [31:0]       rpt_timestamp;
  logic [AXIS_W-1:0] rpt_axis;
  logic [IDLE_W-1:0] rpt_idle;
  logic [IBLK_W-1:0] rpt_inst_block;
  logic [15:0]       event_count;

  logic              block2, clear2, rpt_ready2;
  logic              rpt_valid2, deadlock_active2;
  logic [31:0]       rpt_timestamp2;
  logic [AXIS_W-1:0] rpt_axis2;
  logic [IDLE_W-1:0] rpt_idle2;
  logic [IBLK_W-1:0] rpt_inst_block2;
  logic [1:0]        event_count2;

  pfb_multichannel_decimator_hls_deadlock_reporter dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .clear(clear),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_timestamp(rpt_timestamp),
    .rpt_axis(rpt_axis), .rpt_idle(rpt_idle), .rpt_inst_block(rpt_inst_block),
    .deadlock_active(deadlock_active), .event_count(event_count)
  );

  pfb_multichannel_decimator_hls_deadlock_reporter #(
    .CONFIRM_CYCLES(1), .CNT_W(2)
  ) dut2 (
    .clock(clock), .reset(reset), .block(block2),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .clear(clear2),
    .rpt_valid(rpt_valid2), .rpt_ready(rpt_ready2), .rpt_timestamp(rpt_timestamp2),
    .rpt_axis(rpt_axis2), .rpt_idle(rpt_idle2), .rpt_inst_block(rpt_inst_block2),
    .deadlock_active(deadlock_active2), .event_count(event_count2)
  );

  int   total = 0;
  int   bad = 0;
  int   hs_count = 0;
  int   ts_model = 0;
  rec_t sb[$];
  rec_t mon_exp;
  rec_t held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ts_model tracks the timestamp the DUT will sample at the next edge
  task automatic step();
    @(posedge clock);
    if (reset) ts_model = 0;
    else ts_model++;
    #1;
  endtask

  // A transfer happens at the next rising edge when valid&ready hold now
  always @(negedge clock) begin
    if (!reset && !clear && rpt_valid && rpt_ready) begin
      hs_count++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("sb_ts",   64'(rpt_timestamp),  64'(mon_exp.ts));
        check("sb_axis", 64'(rpt_axis),       64'(mon_exp.axis));
        check("sb_idle", 64'(rpt_idle),       64'(mon_exp.idle));
        check("sb_iblk", 64'(rpt_inst_block), 64'(mon_exp.iblk));
      end
    end
  end

  initial begin
    reset = 1'b1; block = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
    block2 = 1'b0; clear2 = 1'b0; rpt_ready2 = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    step(); step();
    check("rst_valid",  64'(rpt_valid), 64'd0);
    check("rst_ts",     64'(rpt_timestamp), 64'd0);
    check("rst_axis",   64'(rpt_axis), 64'd0);
    check("rst_idle",   64'(rpt_idle), 64'd0);
    check("rst_iblk",   64'(rpt_inst_block), 64'd0);
    check("rst_active", 64'(deadlock_active), 64'd0);
    check("rst_count",  64'(event_count), 64'd0);
    check("rst_valid2", 64'(rpt_valid2), 64'd0);
    reset = 1'b0;

    // Too-short block pulse must not confirm
    block = 1'b1;
    for (int i = 0; i < CONF - 1; i++) begin
      step();
      check("short_valid", 64'(rpt_valid), 64'd0);
    end
    block = 1'b0;
    step(); step();
    check("short_count",  64'(event_count), 64'd0);
    check("short_active", 64'(deadlock_active), 64'd0);

    // Confirmed deadlock starting at ts=100, consumer always ready
    for (int i = 0; i < 300 && ts_model != 100; i++) step();
    axis_block_sigs = 12'h0F0; inst_idle_sigs = 6'h2A; inst_block_sigs = 3'h5;
    rpt_ready = 1'b1; block = 1'b1;
    sb.push_back(rec_t'{32'd115, 12'h0F0, 6'h2A, 3'h5});
    repeat (CONF - 1) step();
    check("t2_early", 64'(rpt_valid), 64'd0);
    step();
    check("t2_valid",  64'(rpt_valid), 64'd1);
    check("t2_ts",     64'(rpt_timestamp), 64'd115);
    check("t2_axis",   64'(rpt_axis), 64'h0F0);
    check("t2_count",  64'(event_count), 64'd1);
    check("t2_active", 64'(deadlock_active), 64'd1);
    block = 1'b0;
    step();
    check("t2_pulse", 64'(rpt_valid), 64'd0);
    check("t2_hs",    64'(hs_count), 64'd1);
    repeat (CONF - 1) step();
    check("t2_rel_hold", 64'(deadlock_active), 64'd1);
    step();
    check("t2_rel_done", 64'(deadlock_active), 64'd0);

    // Clear in IDLE zeroes the count; then a stalled consumer
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_count", 64'(event_count), 64'd0);
    axis_block_sigs = 12'hA5C; inst_idle_sigs = 6'h11; inst_block_sigs = 3'h2;
    rpt_ready = 1'b0; block = 1'b1;
    held = rec_t'{32'(ts_model + CONF - 1), 12'hA5C, 6'h11, 3'h2};
    sb.push_back(held);
    repeat (CONF) step();
    check("t3_valid", 64'(rpt_valid), 64'd1);
    for (int i = 0; i < 40; i++) begin
      axis_block_sigs = 12'($urandom); inst_idle_sigs = 6'($urandom);
      inst_block_sigs = 3'($urandom); block = 1'($urandom);
      step();
      check("t3_hold_valid", 64'(rpt_valid), 64'd1);
      check("t3_hold_payload", 64'({rpt_timestamp, rpt_axis, rpt_idle, rpt_inst_block}), 64'(held));
    end
    check("t3_no_hs", 64'(hs_count), 64'd1);
    rpt_ready = 1'b1; block = 1'b0;
    step();
    check("t3_hs",    64'(hs_count), 64'd2);
    check("t3_drop",  64'(rpt_valid), 64'd0);
    check("t3_count", 64'(event_count), 64'd1);

    // Chattering block during RELEASE keeps the deadlock latched
    for (int i = 0; i < 100; i++) begin
      block = ((i / 8) % 2) == 0;
      step();
      check("t4_active", 64'(deadlock_active), 64'd1);
      check("t4_valid",  64'(rpt_valid), 64'd0);
    end
    block = 1'b0;
    repeat (CONF - 1) step();
    check("t4_hold", 64'(deadlock_active), 64'd1);
    step();
    check("t4_idle", 64'(deadlock_active), 64'd0);
    check("t4_hs",   64'(hs_count), 64'd2);

    // Clear coincident with a handshake in REPORT
    axis_block_sigs = 12'h321; inst_idle_sigs = 6'h3C; inst_block_sigs = 3'h6;
    rpt_ready = 1'b0; block = 1'b1;
    repeat (CONF) step();
    check("t5_valid", 64'(rpt_valid), 64'd1);
    check("t5_count", 64'(event_count), 64'd2);
    clear = 1'b1; rpt_ready = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clr_valid",  64'(rpt_valid), 64'd0);
    check("t5_clr_count",  64'(event_count), 64'd0);
    check("t5_clr_active", 64'(deadlock_active), 64'd0);
    sb.push_back(rec_t'{32'(ts_model + CONF - 1), 12'h321, 6'h3C, 3'h6});
    repeat (CONF - 1) step();
    check("t5_early", 64'(rpt_valid), 64'd0);
    step();
    check("t5_re_valid", 64'(rpt_valid), 64'd1);
    check("t5_re_count", 64'(event_count), 64'd1);
    block = 1'b0;
    step();
    check("t5_hs", 64'(hs_count), 64'd3);
    repeat (CONF) step();
    check("t5_idle", 64'(deadlock_active), 64'd0);

    // Reset while a report is pending
    rpt_ready = 1'b0; block = 1'b1;
    repeat (CONF) step();
    check("t6_valid", 64'(rpt_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; block = 1'b0;
    check("t6_valid_rst",  64'(rpt_valid), 64'd0);
    check("t6_axis_rst",   64'(rpt_axis), 64'd0);
    check("t6_ts_rst",     64'(rpt_timestamp), 64'd0);
    check("t6_count_rst",  64'(event_count), 64'd0);
    check("t6_active_rst", 64'(deadlock_active), 64'd0);

    // Single-cycle confirm and 2-bit saturating count
    axis_block_sigs = 12'h9E1; inst_idle_sigs = 6'h07; inst_block_sigs = 3'h1;
    for (int k = 1; k <= 5; k++) begin
      int exp_ts;
      exp_ts = ts_model;
      block2 = 1'b1; rpt_ready2 = 1'b1;
      step();
      check("d2_valid",  64'(rpt_valid2), 64'd1);
      check("d2_ts",     64'(rpt_timestamp2), 64'(exp_ts));
      check("d2_axis",   64'(rpt_axis2), 64'h9E1);
      check("d2_count",  64'(event_count2), 64'((k > 3) ? 3 : k));
      check("d2_active", 64'(deadlock_active2), 64'd1);
      block2 = 1'b0;
      step();
      check("d2_drop", 64'(rpt_valid2), 64'd0);
      step();
      check("d2_idle", 64'(deadlock_active2), 64'd0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pfb_multichannel_decimator_hls_deadlock_reporter.md
Name: pfb_multichannel_decimator_hls_deadlock_reporter

Overview:
- Sits downstream of the top-level HLS dataflow deadlock monitor and consumes its registered `block` flag.
- Debounces `block`: a deadlock is confirmed only after `block` stays high for CONFIRM_CYCLES consecutive cycles.
- On confirmation, snapshots the AXIS-block, idle and channel-block vectors plus a free-running timestamp, then emits one report record over a valid/ready interface.
- Re-arms only after `block` has been continuously low for CONFIRM_CYCLES cycles. Also keeps a saturating event count for debug readout.

Parameters:
- AXIS_W, 12, width of axis_block_sigs / rpt_axis
- IDLE_W, 6, width of inst_idle_sigs / rpt_idle
- IBLK_W, 3, width of inst_block_sigs / rpt_inst_block
- CONFIRM_CYCLES, 16, consecutive cycles required to confirm, and to release; legal range 1..65535
- TS_W, 32, timestamp width
- CNT_W, 16, event counter width

Ports:
- clock, input, 1, clock
- reset, input, 1, synchronous, active-high
- block, input, 1, deadlock flag from the monitor
- axis_block_sigs, input, AXIS_W, per-stream AXIS block flags
- inst_idle_sigs, input, IDLE_W, process idle flags
- inst_block_sigs, input, IBLK_W, process channel-block flags
- clear, input, 1, synchronous clear pulse
- rpt_valid, output, 1, report record valid
- rpt_ready, input, 1, report consumer ready
- rpt_timestamp, output, TS_W, timestamp at confirmation
- rpt_axis, output, AXIS_W, snapshot of axis_block_sigs
- rpt_idle, output, IDLE_W, snapshot of inst_idle_sigs
- rpt_inst_block, output, IBLK_W, snapshot of inst_block_sigs
- deadlock_active, output, 1, high while in REPORT or RELEASE
- event_count, output, CNT_W, confirmed deadlocks since reset/clear, saturating

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates on the rising edge of clock.
- Reset values: rpt_valid=0, all rpt_* payloads=0, deadlock_active=0, event_count=0, timestamp counter ts=0, run counter=0, FSM=IDLE.
- Timestamp: ts increments by 1 every cycle and wraps modulo 2^TS_W. ts is not affected by clear.
- Run counter rc: 16-bit; counts consecutive qualifying cycles in IDLE/CONFIRM and in RELEASE.
- FSM states: IDLE, CONFIRM, REPORT, RELEASE.
- IDLE:
  - block=0: stay, rc=0.
  - block=1 and CONFIRM_CYCLES=1: capture, go to REPORT.
  - block=1 otherwise: rc=1, go to CONFIRM.
- CONFIRM:
  - block=0: go to IDLE, rc=0.
  - block=1 and rc==CONFIRM_CYCLES-1: capture, go to REPORT.
  - Otherwise: rc+=1.
- Capture (single edge):
  - Register current-cycle axis_block_sigs, inst_idle_sigs, inst_block_sigs and pre-increment ts into rpt_*.
  - rpt_valid<=1.
  - event_count+=1, saturating at 2^CNT_W-1.
- Latency: with block first sampled high at edge e0, rpt_valid is high after edge e(CONFIRM_CYCLES-1); rpt_timestamp = ts value at that edge.
- REPORT:
  - rpt_valid and payload held stable until rpt_valid&rpt_ready; block is ignored.
  - On handshake: rpt_valid<=0, rc=0, go to RELEASE.
- RELEASE:
  - block=1: rc=0.
  - block=0 and rc==CONFIRM_CYCLES-1: go to IDLE, rc=0.
  - block=0 otherwise: rc+=1.
  - No new report is possible until IDLE is reached.
- deadlock_active: registered, equals (state==REPORT || state==RELEASE). It rises on the capture edge and falls on the edge that enters IDLE.
- clear (priority below reset, above everything else):
  - Next state is IDLE, rc=0, rpt_valid=0, event_count=0; payload registers are held.
  - A coincident rpt_valid&rpt_ready is treated as not transferred; the consumer must discard it.
  - A coincident capture is suppressed and does not increment event_count.
- Reset mid-operation: immediate return to reset values on that edge, including mid-REPORT with rpt_valid high.
- Holding rpt_ready=1 continuously gives a 1-cycle rpt_valid pulse. rpt_valid never depends combinationally on rpt_ready.

Test Plan:
- block high for 15 cycles then low, CONFIRM_CYCLES=16 -> no rpt_valid, event_count=0, deadlock_active=0.
- block high from the cycle when ts=100, axis_block_sigs=0x0F0, inst_idle=0x2A, inst_block=0x5 steady, rpt_ready=1 -> rpt_valid pulse one cycle after edge with ts=115, rpt_timestamp=115, rpt_axis=0x0F0, rpt_idle=0x2A, rpt_inst_block=0x5, event_count=1.
- Same as above with rpt_ready=0 for 40 cycles, inputs changing -> payload stable for 40 cycles; single handshake on ready; event_count=1.
- After handshake, block toggles 1/0 every 8 cycles for 100 cycles, then low for 16 -> deadlock_active stays 1 until the 16th consecutive low cycle; no second report.
- clear asserted during REPORT together with rpt_ready=1 -> rpt_valid=0 next cycle, event_count=0, FSM IDLE; block still high -> new report after 16 further cycles, event_count=1.
- CNT_W=2, five full deadlock/release cycles -> event_count saturates at 3; CONFIRM_CYCLES=1 -> report on the first high sample.
